seq_scheduler: RTL and testbench
================================

Name: seq_scheduler

Overview:
- Controller that sequences the Moore sequencer's display state (N_STATES patterns) and owns the `state` register.
- Arbitrates between manual advance requests (the button-release pulse path) and an automatic dwell timer driven by the 1 kHz `tick_mf` strobe.
- Sits between the button/debounce front end and the pattern datapath; supports manual, auto and paused scheduling modes.

Parameters:
- N_STATES, 4, number of sequencer states; state wraps at N_STATES-1.
- STATE_W, 2, width of the state output; must satisfy 2**STATE_W >= N_STATES.
- DWELL_W, 12, width of the dwell register and tick counter.
- DWELL_RST, 1000, dwell value after reset, in tick_mf ticks (1000 = 1 s).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- tick_mf  in  1  one-cycle 1 kHz strobe.
- manual_req  in  1  one-cycle advance request (button release).
- auto_en  in  1  level; 1 = automatic advance mode.
- pause  in  1  level; freezes auto advance.
- dwell_ms  in  DWELL_W  new dwell value.
- dwell_we  in  1  one-cycle write strobe for dwell_ms.
- state  out  STATE_W  current sequencer state.
- adv  out  1  one-cycle pulse in the cycle after state changes.
- mode  out  2  scheduler FSM state: 00 MANUAL, 01 AUTO, 10 PAUSED.

Behaviour:
- Reset (async assert, sync release), all values below hold while rst_n=0:
  - state=0, adv=0, mode=MANUAL, tick counter=0, dwell_reg=DWELL_RST.
- FSM transitions, evaluated each clk:
  - MANUAL -> AUTO when auto_en=1 and pause=0.
  - AUTO -> PAUSED when pause=1.
  - AUTO -> MANUAL when auto_en=0.
  - PAUSED -> AUTO when pause=0 and auto_en=1.
  - PAUSED -> MANUAL when auto_en=0.
  - auto_en=0 has priority over pause.
  - Entering AUTO clears the tick counter.
- Tick counter:
  - Counts tick_mf strobes only in AUTO; holds its value in PAUSED; held at 0 in MANUAL.
- Expiry:
  - In AUTO, expiry occurs when tick_mf=1 and counter+1 >= eff_dwell, where eff_dwell = max(dwell_reg, 1).
  - On expiry the counter resets to 0.
- Advance:
  - next = (state == N_STATES-1) ? 0 : state+1.
  - state takes next one clk after the request/expiry cycle (registered).
  - adv pulses 1 for exactly one cycle, aligned with the new state value.
- manual_req:
  - Accepted in every mode, including PAUSED.
  - In AUTO or PAUSED it also clears the counter, so the full dwell restarts.
- Simultaneous manual_req and expiry in the same cycle: exactly one advance, counter cleared.
- Requests arriving in the cycle state updates are not lost: each accepted cycle produces one advance. Back-to-back manual_req on consecutive cycles gives two advances.
- dwell_we:
  - Loads dwell_reg on the next edge.
  - The counter is not cleared; the >= comparison means a smaller value already passed expires on the next tick_mf.
  - dwell_ms=0 behaves as 1.
- Mode change to MANUAL mid-count: counter cleared; state unchanged.
- Reset mid-operation: immediate return to the reset values; no adv is generated.

Optional Feature:
- Macro: SEQ_SCHED_DIR_EN.
- Defined:
  - Adds input port dir (1 bit).
  - dir=1 decrements state, wrapping 0 -> N_STATES-1.
  - dir is sampled in the cycle the advance is accepted.
- Undefined:
  - Port absent; the block always increments.

Decomposition:
- Package seq_pkg holds:
  - the sched_mode_t enum: MANUAL=2'b00, AUTO=2'b01, PAUSED=2'b10;
  - the N_STATES and STATE_W defaults;
  - the DWELL_RST constant;
  - the tick rate constant (1 kHz).
- One sub-module, seq_dwell_timer:
  - counter, dwell register, expiry compare;
  - inputs: clk, rst_n, tick_mf, run, hold, clear, dwell_ms, dwell_we;
  - output: expire.
- The top level keeps the FSM, arbitration and state register.

Test Plan:
- Reset: hold rst_n=0 with toggling inputs -> state=0, adv=0, mode=00. Release, then 3 manual_req pulses 10 cycles apart -> state 1, 2, 3, each with one adv pulse.
- Wrap: from state=3, one manual_req -> state=0 and adv=1 for one cycle.
- Auto timing: auto_en=1, dwell_ms=5 written via dwell_we -> advance exactly on the 5th tick_mf after entering AUTO, then every 5 ticks; 4 advances in 20 ticks.
- Pause: pause=1 after 3 ticks, apply 10 ticks, release pause -> advance after 2 more ticks. manual_req while PAUSED advances state and restarts the dwell.
- Collision: manual_req in the same cycle as expiry -> exactly one advance, single adv pulse, next advance 5 ticks later.
- Dwell edge cases: counter=7 with dwell 10, write dwell 3 -> advance on the next tick. Write dwell 0 -> advance on every tick. With SEQ_SCHED_DIR_EN and dir=1 from state=0 -> state=3.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared scheduler mode encoding and default sizing for the sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'b00,
    AUTO   = 2'b01,
    PAUSED = 2'b10
  } sched_mode_t;

  localparam int SEQ_N_STATES = 4;
  localparam int SEQ_STATE_W  = 2;
  localparam int SEQ_DWELL_W  = 12;
  // Dwell after reset, in tick_mf ticks (1000 ticks = 1 s at the tick rate below).
  localparam int SEQ_DWELL_RST = 1000;
  localparam int SEQ_TICK_HZ   = 1000;

endpackage

// File: rtl/seq_dwell_timer.sv
// seq_dwell_timer: dwell register, tick counter and expiry compare for auto advance.
// Latency: expire is combinational in the tick cycle; counter/dwell update on the next clk.
// Backpressure: none; clear wins over counting, dwell_we loads without touching the counter.
module seq_dwell_timer
  import seq_pkg::*;
#(
  parameter int DWELL_W   = SEQ_DWELL_W,
  parameter int DWELL_RST = SEQ_DWELL_RST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_mf,
  input  logic               run,
  input  logic               hold,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell_ms,
  input  logic               dwell_we,
  output logic               expire
);

  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W:0]   w_cnt_inc;
  logic [DWELL_W:0]   w_eff_dwell;

  // A dwell of zero is treated as one so the timer can never stall.
  assign w_eff_dwell = (r_dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, r_dwell};
  // One bit wider so the +1 cannot wrap before the compare.
  assign w_cnt_inc   = {1'b0, r_cnt} + (DWELL_W+1)'(1);
  // >= (not ==) so shrinking the dwell below the current count expires on the next tick.
  assign expire      = run & tick_mf & (w_cnt_inc >= w_eff_dwell);

  // Counter runs in AUTO, freezes in PAUSED, sits at zero otherwise; dwell loads on write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dwell <= DWELL_W'(DWELL_RST);
    end else begin
      if (dwell_we) begin
        r_dwell <= dwell_ms;
      end
      if (clear || expire) begin
        r_cnt <= '0;
      end else if (run) begin
        if (tick_mf) begin
          r_cnt <= w_cnt_inc[DWELL_W-1:0];
        end
      end else if (!hold) begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/seq_scheduler.sv
// seq_scheduler: owns the sequencer state; arbitrates manual advance vs. auto dwell expiry.
// Latency: state and adv update one clk after the cycle a request or expiry is accepted.
// Backpressure: none; every accepted cycle advances once, manual+expiry together advance once.
// Optional: define SEQ_SCHED_DIR_EN to add input dir (1 = step backwards with wrap).
module seq_scheduler
  import seq_pkg::*;
#(
  parameter int N_STATES  = SEQ_N_STATES,
  parameter int STATE_W   = SEQ_STATE_W,
  parameter int DWELL_W   = SEQ_DWELL_W,
  parameter int DWELL_RST = SEQ_DWELL_RST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_mf,
  input  logic               manual_req,
  input  logic               auto_en,
  input  logic               pause,
  input  logic [DWELL_W-1:0] dwell_ms,
  input  logic               dwell_we,
`ifdef SEQ_SCHED_DIR_EN
  input  logic               dir,
`endif
  output logic [STATE_W-1:0] state,
  output logic               adv,
  output logic [1:0]         mode
);

  localparam logic [STATE_W-1:0] LP_LAST = STATE_W'(N_STATES - 1);

  sched_mode_t        r_mode;
  sched_mode_t        w_mode_nxt;
  logic [STATE_W-1:0] r_state;
  logic               r_adv;
  logic [STATE_W-1:0] w_state_inc;
  logic [STATE_W-1:0] w_state_nxt;
  logic               w_run;
  logic               w_hold;
  logic               w_clear;
  logic               w_expire;
  logic               w_accept;

  // Mode transitions; auto_en=0 always wins over pause.
  always_comb begin
    w_mode_nxt = r_mode;
    case (r_mode)
      MANUAL:  if (auto_en && !pause) w_mode_nxt = AUTO;
      AUTO:    if (!auto_en) w_mode_nxt = MANUAL;
               else if (pause) w_mode_nxt = PAUSED;
      PAUSED:  if (!auto_en) w_mode_nxt = MANUAL;
               else if (!pause) w_mode_nxt = AUTO;
      default: w_mode_nxt = MANUAL;
    endcase
  end

  assign w_run  = (r_mode == AUTO);
  assign w_hold = (r_mode == PAUSED);
  // Restart the dwell on a manual step while scheduled, on entering AUTO from MANUAL,
  // and on dropping back to MANUAL. PAUSED->AUTO keeps the count so the dwell resumes.
  assign w_clear = (manual_req && (r_mode != MANUAL)) ||
                   ((w_mode_nxt != r_mode) && ((w_mode_nxt == MANUAL) || (r_mode == MANUAL)));

  assign w_accept    = manual_req | w_expire;
  assign w_state_inc = (r_state == LP_LAST) ? '0 : r_state + STATE_W'(1);

`ifdef SEQ_SCHED_DIR_EN
  logic [STATE_W-1:0] w_state_dec;
  assign w_state_dec = (r_state == '0) ? LP_LAST : r_state - STATE_W'(1);
  assign w_state_nxt = dir ? w_state_dec : w_state_inc;
`else
  assign w_state_nxt = w_state_inc;
`endif

  seq_dwell_timer #(
    .DWELL_W   (DWELL_W),
    .DWELL_RST (DWELL_RST)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_mf  (tick_mf),
    .run      (w_run),
    .hold     (w_hold),
    .clear    (w_clear),
    .dwell_ms (dwell_ms),
    .dwell_we (dwell_we),
    .expire   (w_expire)
  );

  // Scheduler FSM with the state register and the adv pulse aligned to the new state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MANUAL;
      r_state <= '0;
      r_adv   <= 1'b0;
    end else begin
      r_mode <= w_mode_nxt;
      r_adv  <= w_accept;
      if (w_accept) begin
        r_state <= w_state_nxt;
      end
    end
  end

  assign state = r_state;
  assign adv   = r_adv;
  assign mode  = r_mode;

endmodule

// File: tb/tb_seq_scheduler.sv
// tb_seq_scheduler: directed scenarios plus randomized traffic against a cycle reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick_mf;
  logic        manual_req;
  logic        auto_en;
  logic        pause;
  logic [11:0] dwell_ms;
  logic        dwell_we;
  logic        dir;
  logic [1:0]  state;
  logic        adv;
  logic [1:0]  mode;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: mode 0 MANUAL, 1 AUTO, 2 PAUSED.
  int m_mode, m_cnt, m_dwell, m_state, m_adv;

  always #5 clk = ~clk;

  seq_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_mf    (tick_mf),
    .manual_req (manual_req),
    .auto_en    (auto_en),
    .pause      (pause),
    .dwell_ms   (dwell_ms),
    .dwell_we   (dwell_we),
`ifdef SEQ_SCHED_DIR_EN
    .dir        (dir),
`endif
    .state      (state),
    .adv        (adv),
    .mode       (mode)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_dwell = 1000; m_state = 0; m_adv = 0;
  endtask

  // Applies the scheduling rules to the inputs present before the coming edge.
  task automatic model_step();
    int eff, nm, nxt;
    bit expire, acc, down;
    if (!rst_n) begin
      model_reset();
      return;
    end
    eff    = (m_dwell == 0) ? 1 : m_dwell;
    expire = (m_mode == 1) && tick_mf && (m_cnt + 1 >= eff);
    acc    = manual_req || expire;
    if (!auto_en)         nm = 0;
    else if (m_mode == 0) nm = pause ? 0 : 1;
    else                  nm = pause ? 2 : 1;
    if (expire || (manual_req && m_mode != 0)) m_cnt = 0;
    else if (m_mode == 1 && tick_mf)           m_cnt = m_cnt + 1;
    else if (m_mode == 0)                      m_cnt = 0;
    if (nm == 0) m_cnt = 0;
    down = 1'b0;
`ifdef SEQ_SCHED_DIR_EN
    down = dir;
`endif
    if (acc) begin
      nxt     = down ? m_state + 3 : m_state + 1;
      m_state = nxt % 4;
    end
    m_adv  = acc;
    m_mode = nm;
    if (dwell_we) m_dwell = dwell_ms;
  endtask

  // One clock: update model, take the edge, compare, drop the one-cycle strobes.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("state", int'(state), m_state);
    chk("adv",   int'(adv),   m_adv);
    chk("mode",  int'(mode),  m_mode);
    manual_req = 1'b0;
    tick_mf    = 1'b0;
    dwell_we   = 1'b0;
  endtask

  // n tick_mf strobes, two idle cycles apart; returns the number of adv pulses seen.
  task automatic ticks(input int n, output int advs);
    advs = 0;
    for (int i = 0; i < n; i++) begin
      tick_mf = 1'b1;
      cyc();
      if (adv) advs++;
      cyc();
      cyc();
    end
  endtask

  task automatic write_dwell(input int v);
    dwell_ms = 12'(v);
    dwell_we = 1'b1;
    cyc();
  endtask

  int a;
  int saved;

  initial begin
    rst_n = 1'b0; tick_mf = 0; manual_req = 0; auto_en = 0; pause = 0;
    dwell_ms = '0; dwell_we = 0; dir = 0;
    model_reset();

    // Reset held with toggling inputs.
    for (int i = 0; i < 6; i++) begin
      tick_mf = 1'($urandom); manual_req = 1'($urandom); auto_en = 1'($urandom);
      pause = 1'($urandom); dwell_we = 1'($urandom); dwell_ms = 12'($urandom);
      cyc();
      chk("rst_state", int'(state), 0);
      chk("rst_mode",  int'(mode),  0);
    end
    auto_en = 0; pause = 0; dwell_ms = '0;
    rst_n = 1'b1;
    cyc();

    // Three manual steps then wrap.
    for (int k = 1; k <= 4; k++) begin
      manual_req = 1'b1;
      cyc();
      chk("man_state", int'(state), k % 4);
      chk("man_adv",   int'(adv),   1);
      cyc();
      chk("man_adv_off", int'(adv), 0);
      repeat (8) cyc();
    end

    // Auto timing with dwell 5.
    write_dwell(5);
    auto_en = 1'b1;
    cyc();
    chk("auto_mode", int'(mode), 1);
    ticks(4, a);  chk("auto_first4", a, 0);
    ticks(1, a);  chk("auto_5th", a, 1);
    ticks(15, a); chk("auto_rest", a, 3);

    // Pause holds the count.
    ticks(3, a);
    pause = 1'b1; cyc();
    chk("pause_mode", int'(mode), 2);
    ticks(10, a); chk("paused_ticks", a, 0);
    pause = 1'b0; cyc();
    ticks(1, a);  chk("resume_1", a, 0);
    ticks(1, a);  chk("resume_2", a, 1);

    // Manual step while paused restarts the dwell.
    ticks(2, a);
    pause = 1'b1; cyc();
    saved = int'(state);
    manual_req = 1'b1; cyc();
    chk("pause_man_adv", int'(adv), 1);
    chk("pause_man_state", int'(state), (saved + 1) % 4);
    pause = 1'b0; cyc();
    ticks(4, a);  chk("restart_4", a, 0);
    ticks(1, a);  chk("restart_5", a, 1);

    // Manual request colliding with expiry.
    ticks(4, a);
    saved = int'(state);
    tick_mf = 1'b1; manual_req = 1'b1; cyc();
    chk("coll_adv", int'(adv), 1);
    chk("coll_state", int'(state), (saved + 1) % 4);
    cyc();
    chk("coll_adv_off", int'(adv), 0);
    ticks(4, a);  chk("coll_next4", a, 0);
    ticks(1, a);  chk("coll_next5", a, 1);

    // Dwell shrunk below the running count, then dwell 0.
    write_dwell(10);
    ticks(7, a);  chk("dw10_7", a, 0);
    write_dwell(3);
    ticks(1, a);  chk("dw3_next", a, 1);
    write_dwell(0);
    ticks(3, a);  chk("dw0_each", a, 3);

    // Dropping to MANUAL mid-count clears the count but keeps the state.
    write_dwell(5);
    ticks(2, a);
    saved = int'(state);
    auto_en = 1'b0; cyc();
    chk("to_man_mode", int'(mode), 0);
    chk("to_man_state", int'(state), saved);
    auto_en = 1'b1; cyc();
    ticks(4, a);  chk("re_auto_4", a, 0);
    ticks(1, a);  chk("re_auto_5", a, 1);

    // Asynchronous reset mid-operation.
    rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state), 0);
    chk("arst_adv",   int'(adv),   0);
    chk("arst_mode",  int'(mode),  0);
    model_reset();
    cyc();
    rst_n = 1'b1; auto_en = 1'b0;
    cyc();

`ifdef SEQ_SCHED_DIR_EN
    dir = 1'b1; manual_req = 1'b1; cyc();
    chk("dir_wrap", int'(state), 3);
    dir = 1'b0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      manual_req = ($urandom % 16) == 0;
      tick_mf    = ($urandom % 4) == 0;
      dwell_we   = ($urandom % 64) == 0;
      dwell_ms   = 12'($urandom_range(0, 7));
      dir        = 1'($urandom);
      if (($urandom % 100) == 0) auto_en = ~auto_en;
      if (($urandom % 50) == 0)  pause   = ~pause;
      rst_n = ($urandom % 700) != 0;
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
